// File: rtl/multicycle_controller.sv
// Main control FSM and ALU decoder for the multicycle RV32I datapath.
// Sequences each instruction through fetch/decode/execute/memory/writeback and drives the datapath controls.
module multicycle_controller #(
   parameter bit ERR_STICKY = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       RegWrite,
   output logic [2:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic       illegal,
   output logic [3:0] stateOut
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      ALUWB    = 4'd7,
      EXECI    = 4'd8,
      JAL      = 4'd9,
      BEQ      = 4'd10,
      ERROR    = 4'd15
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   state_t     state;
   state_t     next_state;
   logic [1:0] alu_op;
   logic       pc_update;
   logic       branch;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic       alu_f3_ok;
   logic       r_f7_bad;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values together.
      if (!rst_n) state <= FETCH;
      else        state <= next_state;
   end

   assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                      (funct3 == 3'b110) || (funct3 == 3'b111);
   assign r_f7_bad  = (op == OP_R) && funct7b5 && (funct3 != 3'b000);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      next_state = ERROR;
      pc_update  = 1'b0;
      branch     = 1'b0;
      AdrSrc     = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      alu_op     = 2'b00;
      illegal    = 1'b0;
      case (state)
         FETCH: begin
            ir_write   = 1'b1;
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            pc_update  = 1'b1;
            next_state = DECODE;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_R:         next_state = (alu_f3_ok && !r_f7_bad) ? EXECR : ERROR;
               OP_I:         next_state = alu_f3_ok ? EXECI : ERROR;
               OP_JAL:       next_state = JAL;
               OP_BEQ:       next_state = (funct3 == 3'b000) ? BEQ : ERROR;
               default:      next_state = ERROR;
            endcase
         end
         MEMADR: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            next_state = op[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            AdrSrc     = 1'b1;
            next_state = MEMWB;
         end
         MEMWB: begin
            ResultSrc  = 2'b01;
            reg_write  = 1'b1;
            next_state = FETCH;
         end
         MEMWRITE: begin
            AdrSrc     = 1'b1;
            mem_write  = 1'b1;
            next_state = FETCH;
         end
         EXECR: begin
            ALUSrcA    = 2'b10;
            alu_op     = 2'b10;
            next_state = ALUWB;
         end
         EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            alu_op     = 2'b10;
            next_state = ALUWB;
         end
         ALUWB: begin
            reg_write  = 1'b1;
            next_state = FETCH;
         end
         JAL: begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            pc_update  = 1'b1;
            next_state = ALUWB;
         end
         BEQ: begin
            ALUSrcA    = 2'b10;
            alu_op     = 2'b01;
            branch     = 1'b1;
            next_state = FETCH;
         end
         ERROR: begin
            illegal    = 1'b1;
            next_state = ERR_STICKY ? ERROR : FETCH;
         end
         default: next_state = ERROR;
      endcase
   end

   // Enables are gated by rst_n so an aborted instruction never commits a write.
   assign PCWrite  = rst_n & (pc_update | (branch & zero));
   assign MemWrite = rst_n & mem_write;
   assign IRWrite  = rst_n & ir_write;
   assign RegWrite = rst_n & reg_write;
   assign stateOut = state;

   always_comb begin
      ALUControl = 3'b000;
      case (alu_op)
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   always_comb begin
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instruction sequences push expected
// per-cycle control words; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op = 7'b0000011;
   logic [2:0] funct3 = 3'b000;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] stateOut;

   int checks = 0;
   int errors = 0;

   string       tag_q[$];
   logic [20:0] exp_q[$];

   logic [6:0] nxt_op = 7'b0000011;
   logic [2:0] nxt_f3 = 3'b000;
   logic       nxt_f7 = 1'b0;
   logic [1:0] nxt_imm = 2'b00;
   logic [1:0] cur_imm = 2'b00;

   multicycle_controller dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
      .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal), .stateOut(stateOut)
   );

   always #5 clk = ~clk;

   // Expected control word for a state, straight from the state output table.
   function automatic logic [20:0] expect_for(input logic [3:0] st, input logic [2:0] aluc,
                                             input logic [1:0] imm, input logic z, input logic r);
      logic pcw, adr, mw, irw, rw, ill;
      logic [1:0] rs, sa, sb;
      {pcw, adr, mw, irw, rw, ill} = 6'b0;
      {rs, sa, sb} = 6'b0;
      case (st)
         4'd0:  begin irw = 1'b1; sb = 2'b10; rs = 2'b10; pcw = 1'b1; end
         4'd1:  begin sa = 2'b01; sb = 2'b01; end
         4'd2:  begin sa = 2'b10; sb = 2'b01; end
         4'd3:  adr = 1'b1;
         4'd4:  begin rs = 2'b01; rw = 1'b1; end
         4'd5:  begin adr = 1'b1; mw = 1'b1; end
         4'd6:  sa = 2'b10;
         4'd7:  rw = 1'b1;
         4'd8:  begin sa = 2'b10; sb = 2'b01; end
         4'd9:  begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
         4'd10: begin sa = 2'b10; pcw = z; end
         4'd15: ill = 1'b1;
         default: ;
      endcase
      if (!r) {pcw, mw, irw, rw} = 4'b0;
      return {st, pcw, adr, mw, irw, rs, sa, sb, rw, aluc, imm, ill};
   endfunction

   task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic [1:0] imm);
      nxt_op = o; nxt_f3 = f3; nxt_f7 = f7; nxt_imm = imm;
   endtask

   // Apply inputs, take one edge, queue the expected word for the cycle that follows.
   task automatic step(input string tag, input logic [3:0] st, input logic [2:0] aluc,
                       input logic z = 1'b0, input logic r = 1'b1);
      op = nxt_op; funct3 = nxt_f3; funct7b5 = nxt_f7; cur_imm = nxt_imm;
      zero = z; rst_n = r;
      @(posedge clk); #1;
      tag_q.push_back(tag);
      exp_q.push_back(expect_for(st, aluc, cur_imm, z, r));
      @(negedge clk); #1;
   endtask

   // Edge taken with rst_n low, then rst_n released inside the FETCH cycle.
   task automatic release_reset(input string tag);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tag_q.push_back(tag);
      exp_q.push_back(expect_for(4'd0, 3'b000, cur_imm, zero, 1'b1));
      @(negedge clk); #1;
   endtask

   initial begin : monitor
      logic [20:0] act, exp;
      string tag;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            act = {stateOut, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   RegWrite, ALUControl, ImmSrc, illegal};
            checks++;
            if (act !== exp) begin
               errors++;
               $display("FAIL %s: got %b expected %b (st/pcw/adr/mw/irw/rs/sa/sb/rw/aluc/imm/ill)",
                        tag, act, exp);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      set_instr(7'b0000011, 3'b000, 1'b0, 2'b00);
      step("rst_hold", 4'd0, 3'b000, 1'b0, 1'b0);
      release_reset("rst_release");

      // sub
      set_instr(7'b0110011, 3'b000, 1'b1, 2'b00);
      step("sub_decode", 4'd1, 3'b000);
      step("sub_execr", 4'd6, 3'b001);
      step("sub_aluwb", 4'd7, 3'b000);
      step("sub_fetch", 4'd0, 3'b000);

      // lw, zero toggled in MEMREAD must not move the PC
      set_instr(7'b0000011, 3'b010, 1'b0, 2'b00);
      step("lw_decode", 4'd1, 3'b000);
      step("lw_memadr", 4'd2, 3'b000);
      step("lw_memread", 4'd3, 3'b000, 1'b1);
      step("lw_memwb", 4'd4, 3'b000);
      step("lw_fetch", 4'd0, 3'b000);

      // sw
      set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
      step("sw_decode", 4'd1, 3'b000);
      step("sw_memadr", 4'd2, 3'b000);
      step("sw_memwrite", 4'd5, 3'b000);
      step("sw_fetch", 4'd0, 3'b000);

      // beq taken
      set_instr(7'b1100011, 3'b000, 1'b0, 2'b10);
      step("beq1_decode", 4'd1, 3'b000, 1'b1);
      step("beq1_beq", 4'd10, 3'b001, 1'b1);
      step("beq1_fetch", 4'd0, 3'b000);

      // beq not taken
      step("beq0_decode", 4'd1, 3'b000, 1'b1);
      step("beq0_beq", 4'd10, 3'b001, 1'b0);
      step("beq0_fetch", 4'd0, 3'b000, 1'b1);

      // slti
      set_instr(7'b0010011, 3'b010, 1'b0, 2'b00);
      step("slti_decode", 4'd1, 3'b000);
      step("slti_execi", 4'd8, 3'b101);
      step("slti_aluwb", 4'd7, 3'b000);
      step("slti_fetch", 4'd0, 3'b000);

      // addi with bit 30 set is still add (op[5]=0)
      set_instr(7'b0010011, 3'b000, 1'b1, 2'b00);
      step("addi_decode", 4'd1, 3'b000);
      step("addi_execi", 4'd8, 3'b000);
      step("addi_aluwb", 4'd7, 3'b000);
      step("addi_fetch", 4'd0, 3'b000);

      // or
      set_instr(7'b0110011, 3'b110, 1'b0, 2'b00);
      step("or_decode", 4'd1, 3'b000);
      step("or_execr", 4'd6, 3'b011);
      step("or_aluwb", 4'd7, 3'b000);
      step("or_fetch", 4'd0, 3'b000);

      // andi
      set_instr(7'b0010011, 3'b111, 1'b0, 2'b00);
      step("andi_decode", 4'd1, 3'b000);
      step("andi_execi", 4'd8, 3'b010);
      step("andi_aluwb", 4'd7, 3'b000);
      step("andi_fetch", 4'd0, 3'b000);

      // jal
      set_instr(7'b1101111, 3'b000, 1'b0, 2'b11);
      step("jal_decode", 4'd1, 3'b000);
      step("jal_jal", 4'd9, 3'b000);
      step("jal_aluwb", 4'd7, 3'b000);
      step("jal_fetch", 4'd0, 3'b000);

      // sw aborted by reset in MEMWRITE
      set_instr(7'b0100011, 3'b000, 1'b0, 2'b01);
      step("swrst_decode", 4'd1, 3'b000);
      step("swrst_memadr", 4'd2, 3'b000);
      step("swrst_memwrite", 4'd5, 3'b000);
      step("swrst_reset", 4'd0, 3'b000, 1'b0, 1'b0);
      release_reset("swrst_release");

      // illegal I-type funct3 -> sticky ERROR
      set_instr(7'b0010011, 3'b001, 1'b0, 2'b00);
      step("ill_decode", 4'd1, 3'b000);
      for (int i = 0; i < 10; i++) begin
         step($sformatf("ill_error%0d", i), 4'd15, 3'b000, logic'(i % 2));
      end
      step("ill_reset", 4'd0, 3'b000, 1'b0, 1'b0);
      release_reset("ill_release");

      // R-type with funct7b5 and funct3 != 000 is illegal
      set_instr(7'b0110011, 3'b010, 1'b1, 2'b00);
      step("rbad_decode", 4'd1, 3'b000);
      step("rbad_error", 4'd15, 3'b000);
      step("rbad_reset", 4'd0, 3'b000, 1'b0, 1'b0);
      release_reset("rbad_release");

      // unknown opcode
      set_instr(7'b1111111, 3'b000, 1'b0, 2'b00);
      step("unk_decode", 4'd1, 3'b000);
      step("unk_error", 4'd15, 3'b000);

      repeat (2) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
